branch_unit_ras: RTL and testbench

Parametrised next-generation branch decision unit for the RISC core's execute stage. It resolves unconditional jumps, register jumps, eight flag-conditional branches, calls and returns, and adds a few features: a flag register with write enable, a return-address stack (RAS) for call/return, registered outputs, and a programmable post-branch flush window. It sits between decode/ALU (opcode, function code, flags) and the PC update logic.

---
 rtl/branch_unit_ras.sv | 152 +++++++++++++++
 tb/tb_branch_unit_ras.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit_ras.sv
// Execute-stage branch decision unit with a flag register, a circular return-address
// stack and a post-branch flush window; branch/target are registered (latency 1).
module branch_unit_ras #(
  parameter int PC_W      = 16,
  parameter int DATA_W    = 32,
  parameter int RAS_DEPTH = 8,
  parameter int FLUSH_CYC = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid,
  input  logic [3:0]                     opcode,
  input  logic [3:0]                     fncode,
  input  logic [PC_W-1:0]                offset_in,
  input  logic [DATA_W-1:0]              rs_value,
  input  logic [PC_W-1:0]                ret_addr,
  input  logic                           flag_we,
  input  logic                           zflag_in,
  input  logic                           oflag_in,
  input  logic                           cflag_in,
  input  logic                           sflag_in,
  output logic                           branch,
  output logic [PC_W-1:0]                target,
  output logic                           flush,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_udf
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int FCW   = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  logic              zflag, oflag, cflag, sflag;
  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W-1:0]  ptr_inc, ptr_top;
  logic [FCW-1:0]    flush_cnt;
  logic              accept, cond_true, ras_full, ras_empty;
  logic              dec_taken, dec_push, dec_pop, dec_udf;
  logic [PC_W-1:0]   dec_target;

  if (DATA_W > PC_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^rs_value[DATA_W-1:PC_W];
  end

  assign flush     = (flush_cnt != '0);
  assign accept    = valid && !flush;
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  // ras_ptr is the next write slot; the newest entry sits one below it, wrapping.
  assign ptr_inc = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PTR_W'(1);
  assign ptr_top = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - PTR_W'(1);

  always_comb begin
    cond_true = 1'b0;
    case (fncode[2:0])
      3'd0: cond_true = zflag;
      3'd1: cond_true = !zflag;
      3'd2: cond_true = cflag;
      3'd3: cond_true = !cflag;
      3'd4: cond_true = sflag;
      3'd5: cond_true = !sflag;
      3'd6: cond_true = oflag;
      default: cond_true = !oflag;
    endcase
  end

  always_comb begin
    dec_taken  = 1'b0;
    dec_target = '0;
    dec_push   = 1'b0;
    dec_pop    = 1'b0;
    dec_udf    = 1'b0;
    case ({opcode, fncode})
      8'h60: begin
        dec_taken  = 1'b1;
        dec_target = offset_in;
      end
      8'h61: begin
        dec_taken  = 1'b1;
        dec_target = rs_value[PC_W-1:0];
      end
      8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77: begin
        dec_taken  = cond_true;
        dec_target = offset_in;
      end
      8'h80: begin
        dec_taken  = 1'b1;
        dec_target = offset_in;
        dec_push   = 1'b1;
      end
      8'h81: begin
        dec_taken = 1'b1;
        if (!ras_empty) begin
          dec_target = ras_mem[ptr_top];
          dec_pop    = 1'b1;
        end else begin
          dec_target = rs_value[PC_W-1:0];
          dec_udf    = 1'b1;
        end
      end
      default: dec_taken = 1'b0;
    endcase
  end

  // Conditions above read the pre-update flags, so a same-cycle flag_we has no effect on them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zflag     <= 1'b0;
      oflag     <= 1'b0;
      cflag     <= 1'b0;
      sflag     <= 1'b0;
      branch    <= 1'b0;
      target    <= '0;
      ras_ptr   <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_udf   <= 1'b0;
      flush_cnt <= '0;
    end else begin
      if (flag_we) begin
        zflag <= zflag_in;
        oflag <= oflag_in;
        cflag <= cflag_in;
        sflag <= sflag_in;
      end
      branch <= accept && dec_taken;
      target <= (accept && dec_taken) ? dec_target : '0;
      if (accept && dec_push) begin
        ras_ptr <= ptr_inc;
        if (ras_full) ras_ovf <= 1'b1;
        else          ras_count <= ras_count + CNT_W'(1);
      end
      if (accept && dec_pop) begin
        ras_ptr   <= ptr_top;
        ras_count <= ras_count - CNT_W'(1);
      end
      if (accept && dec_udf) ras_udf <= 1'b1;
      if (accept && dec_taken)  flush_cnt <= FCW'(FLUSH_CYC);
      else if (flush_cnt != '0) flush_cnt <= flush_cnt - FCW'(1);
    end
  end

  // Stack storage needs no reset; a full push simply overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (accept && dec_push) ras_mem[ras_ptr] <= ret_addr;
  end

endmodule

// File: tb/tb_branch_unit_ras.sv
// Directed self-checking bench for branch_unit_ras with default parameters
// (PC_W=16, DATA_W=32, RAS_DEPTH=8, FLUSH_CYC=2).
module tb_branch_unit_ras;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  opcode = '0, fncode = '0;
  logic [15:0] offset_in = '0, ret_addr = '0;
  logic [31:0] rs_value = '0;
  logic        flag_we = 1'b0, zflag_in = 1'b0, oflag_in = 1'b0, cflag_in = 1'b0, sflag_in = 1'b0;
  logic        branch, flush, ras_ovf, ras_udf;
  logic [15:0] target;
  logic [3:0]  ras_count;

  int tests_run = 0;
  int tests_failed = 0;

  branch_unit_ras dut (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .fncode(fncode),
    .offset_in(offset_in), .rs_value(rs_value), .ret_addr(ret_addr),
    .flag_we(flag_we), .zflag_in(zflag_in), .oflag_in(oflag_in),
    .cflag_in(cflag_in), .sflag_in(sflag_in), .branch(branch), .target(target),
    .flush(flush), .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_udf(ras_udf)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] code, input logic [15:0] off,
                       input logic [31:0] rs, input logic [15:0] ra);
    valid     = v;
    opcode    = code[7:4];
    fncode    = code[3:0];
    offset_in = off;
    rs_value  = rs;
    ret_addr  = ra;
  endtask

  task automatic set_flags(input logic z, input logic o, input logic c, input logic s);
    flag_we = 1'b1; zflag_in = z; oflag_in = o; cflag_in = c; sflag_in = s;
  endtask

  task automatic idle_out_flush();
    drive(1'b0, 8'h00, 16'h0, 32'h0, 16'h0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if (branch !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_branch: got %0b want 0", branch); end
    tests_run++; if (target !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_target: got %h want 0000", target); end
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flush: got %0b want 0", flush); end
    tests_run++; if (ras_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d want 0", ras_count); end
    tests_run++; if ({ras_ovf, ras_udf} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_sticky: got %b want 00", {ras_ovf, ras_udf}); end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_cond_basic();
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    flag_we = 1'b0;
    drive(1'b1, 8'h70, 16'h0040, 32'h0, 16'h0);
    tick();
    tests_run++; if (branch !== 1'b1) begin tests_failed++; $display("[TB] FAIL beq_branch: got %0b want 1", branch); end
    tests_run++; if (target !== 16'h0040) begin tests_failed++; $display("[TB] FAIL beq_target: got %h want 0040", target); end
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("[TB] FAIL beq_flush1: got %0b want 1", flush); end
    drive(1'b0, 8'h00, 16'h0, 32'h0, 16'h0);
    tick();
    tests_run++; if ({branch, target} !== 17'h0) begin tests_failed++; $display("[TB] FAIL beq_pulse_end: got %0b/%h want 0/0000", branch, target); end
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("[TB] FAIL beq_flush2: got %0b want 1", flush); end
    tick();
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("[TB] FAIL beq_flush3: got %0b want 0", flush); end
    drive(1'b1, 8'h71, 16'h0040, 32'h0, 16'h0);
    tick();
    tests_run++; if ({branch, target} !== 17'h0) begin tests_failed++; $display("[TB] FAIL bne_not_taken: got %0b/%h want 0/0000", branch, target); end
    drive(1'b0, 8'h00, 16'h0, 32'h0, 16'h0);
    tick();
  endtask

  task automatic test_flag_hazard();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h70, 16'h0050, 32'h0, 16'h0);
    tick();
    flag_we = 1'b0;
    tests_run++; if (branch !== 1'b0) begin tests_failed++; $display("[TB] FAIL hazard_old_flags: got %0b want 0", branch); end
    tick();
    tests_run++; if (branch !== 1'b1 || target !== 16'h0050) begin tests_failed++; $display("[TB] FAIL hazard_new_flags: got %0b/%h want 1/0050", branch, target); end
    idle_out_flush();
  endtask

  task automatic test_conditions();
    logic [7:0] expect_taken;
    expect_taken = 8'b0110_0110;
    set_flags(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    flag_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h70 + 8'(i), 16'h0100 + 16'(i), 32'h0, 16'h0);
      tick();
      tests_run++;
      if (branch !== expect_taken[i] || target !== (expect_taken[i] ? 16'h0100 + 16'(i) : 16'h0)) begin
        tests_failed++;
        $display("[TB] FAIL cond_7%0d: got %0b/%h want %0b", i, branch, target, expect_taken[i]);
      end
      idle_out_flush();
    end
    drive(1'b1, 8'h61, 16'h0, 32'h1234_5678, 16'h0);
    tick();
    tests_run++; if (branch !== 1'b1 || target !== 16'h5678) begin tests_failed++; $display("[TB] FAIL jr: got %0b/%h want 1/5678", branch, target); end
    idle_out_flush();
    drive(1'b1, 8'h62, 16'h0777, 32'h0, 16'h0);
    tick();
    tests_run++; if (branch !== 1'b0 || flush !== 1'b0) begin tests_failed++; $display("[TB] FAIL unknown_code: got br=%0b fl=%0b want 0/0", branch, flush); end
    drive(1'b0, 8'h00, 16'h0, 32'h0, 16'h0);
    tick();
  endtask

  task automatic test_call_return();
    drive(1'b1, 8'h80, 16'h0100, 32'h0, 16'h0011);
    tick();
    tests_run++; if (branch !== 1'b1 || target !== 16'h0100 || ras_count !== 4'd1) begin tests_failed++; $display("[TB] FAIL call1: got %0b/%h/%0d want 1/0100/1", branch, target, ras_count); end
    idle_out_flush();
    drive(1'b1, 8'h80, 16'h0200, 32'h0, 16'h0022);
    tick();
    tests_run++; if (ras_count !== 4'd2) begin tests_failed++; $display("[TB] FAIL call2_count: got %0d want 2", ras_count); end
    idle_out_flush();
    drive(1'b1, 8'h81, 16'h0, 32'h0, 16'h0);
    tick();
    tests_run++; if (target !== 16'h0022 || ras_count !== 4'd1) begin tests_failed++; $display("[TB] FAIL ret1: got %h/%0d want 0022/1", target, ras_count); end
    idle_out_flush();
    drive(1'b1, 8'h81, 16'h0, 32'h0, 16'h0);
    tick();
    tests_run++; if (target !== 16'h0011 || ras_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL ret2: got %h/%0d want 0011/0", target, ras_count); end
    tests_run++; if ({ras_ovf, ras_udf} !== 2'b00) begin tests_failed++; $display("[TB] FAIL callret_sticky: got %b want 00", {ras_ovf, ras_udf}); end
    idle_out_flush();
  endtask

  task automatic test_ras_overflow();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 8'h80, 16'h0300, 32'h0, 16'(i));
      tick();
      idle_out_flush();
    end
    tests_run++; if (ras_ovf !== 1'b1 || ras_count !== 4'd8) begin tests_failed++; $display("[TB] FAIL ovf: got ovf=%0b cnt=%0d want 1/8", ras_ovf, ras_count); end
    for (int k = 9; k >= 2; k--) begin
      drive(1'b1, 8'h81, 16'h0, 32'h0, 16'h0);
      tick();
      tests_run++; if (target !== 16'(k)) begin tests_failed++; $display("[TB] FAIL ovf_pop: got %h want %h", target, 16'(k)); end
      idle_out_flush();
    end
    drive(1'b1, 8'h81, 16'h0, 32'h0000_ABCD, 16'h0);
    tick();
    tests_run++; if (target !== 16'hABCD || ras_udf !== 1'b1 || ras_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL udf: got %h/udf=%0b/cnt=%0d want ABCD/1/0", target, ras_udf, ras_count); end
    idle_out_flush();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'h60, 16'h0400, 32'h0, 16'h0);
    tick();
    tests_run++; if (branch !== 1'b1 || target !== 16'h0400) begin tests_failed++; $display("[TB] FAIL b2b_first: got %0b/%h want 1/0400", branch, target); end
    drive(1'b1, 8'h60, 16'h0500, 32'h0, 16'h0);
    tick();
    tests_run++; if (branch !== 1'b0 || flush !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_squash1: got br=%0b fl=%0b want 0/1", branch, flush); end
    tick();
    tests_run++; if (branch !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_squash2: got %0b want 0", branch); end
    tick();
    tests_run++; if (branch !== 1'b1 || target !== 16'h0500) begin tests_failed++; $display("[TB] FAIL b2b_third: got %0b/%h want 1/0500", branch, target); end
    idle_out_flush();
  endtask

  task automatic test_reset_mid_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h80, 16'h0600, 32'h0, 16'h0021 + 16'(i));
      tick();
      idle_out_flush();
    end
    drive(1'b1, 8'h60, 16'h0700, 32'h0, 16'h0);
    tick();
    drive(1'b0, 8'h00, 16'h0, 32'h0, 16'h0);
    tests_run++; if (flush !== 1'b1 || ras_count !== 4'd3) begin tests_failed++; $display("[TB] FAIL prereset: got fl=%0b cnt=%0d want 1/3", flush, ras_count); end
    rst = 1'b0;
    #1;
    tests_run++; if ({branch, flush} !== 2'b00 || ras_count !== 4'd0 || target !== 16'h0) begin tests_failed++; $display("[TB] FAIL midreset: got br=%0b fl=%0b cnt=%0d tgt=%h want all 0", branch, flush, ras_count, target); end
    tests_run++; if ({ras_ovf, ras_udf} !== 2'b00) begin tests_failed++; $display("[TB] FAIL midreset_sticky: got %b want 00", {ras_ovf, ras_udf}); end
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b1, 8'h81, 16'h0, 32'h0000_BEEF, 16'h0);
    tick();
    tests_run++; if (branch !== 1'b1 || target !== 16'hBEEF || ras_udf !== 1'b1 || ras_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL post_reset_ret: got %0b/%h/udf=%0b/cnt=%0d want 1/BEEF/1/0", branch, target, ras_udf, ras_count); end
    drive(1'b0, 8'h00, 16'h0, 32'h0, 16'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_cond_basic();
    test_flag_hazard();
    test_conditions();
    test_call_return();
    test_ras_overflow();
    test_back_to_back();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
